count_seq_ctrl: RTL and testbench

Sequencer and arbiter for the shared 3-bit loadable counter. Up to NREQ requesters each submit a job: a start value and a number of increments. The block grants one job at a time in round-robin order and drives the counter's load and enable inputs. When the job finishes it returns the final count to the requester with a one-cycle acknowledge. It sits between the requesting control logic and the counter instance at the top level.

---
 rtl/cseq_pkg.sv | 17 +
 rtl/cseq_rr_arb.sv | 51 +++++
 rtl/count_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_count_seq_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/cseq_pkg.sv
// rtl/cseq_pkg.sv - shared types and default widths for the counter sequencer
// Purpose: FSM state encoding and default counter/run-length widths used by
//          count_seq_ctrl and cseq_rr_arb.
// Ports:   none (package).
package cseq_pkg;

  localparam int CSEQ_CW = 3;  // default counter width
  localparam int CSEQ_LW = 4;  // default run-length width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } cseq_state_e;

endpackage

// File: rtl/cseq_rr_arb.sv
// rtl/cseq_rr_arb.sv - round-robin requester pick with registered last-grant pointer
// Purpose: combinationally picks the first requesting index at or after
//          (last granted + 1) mod NREQ; the pointer moves only on grant_en.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   req       in   NREQ request levels
//   grant_en  in   the caller accepted the current pick this cycle
//   gnt_valid out  at least one request is pending
//   gnt_id    out  picked requester index
module cseq_rr_arb
  import cseq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_id
);

  logic [IW-1:0] ptr_q;  // last granted requester
  logic [IW-1:0] cand;

  // Walk the ring starting one past the last grant; the first hit wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
    end
  end

  // Resetting the pointer to the last index gives requester 0 first priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= IW'(NREQ - 1);
    end else if (grant_en) begin
      ptr_q <= gnt_id;
    end
  end

endmodule

// File: rtl/count_seq_ctrl.sv
// rtl/count_seq_ctrl.sv - job sequencer and arbiter for the shared loadable counter
// Purpose: grants one requester job at a time (round-robin), loads the counter
//          with the job's start value, enables it for the job's length, then
//          returns the final count with a one-cycle one-hot ack.
// Optional feature: CSEQ_WRAP_STOP_EN ends a job early on counter wrap.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req             per-requester request level
//   req_start       packed start values, requester i at [i*CW +: CW]
//   req_len         packed increment counts, requester i at [i*LW +: LW]
//   ack             one-hot job-complete pulse
//   result          counter value at completion (valid with ack)
//   wrapped         job ended on counter wrap (valid with ack)
//   busy            high outside IDLE
//   grant_id        current or last granted requester
//   ctr_ld, ctr_en, ctr_ld_val   counter controls
//   ctr_count       counter value
module count_seq_ctrl
  import cseq_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int CW   = CSEQ_CW,
  parameter int LW   = CSEQ_LW,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] req_start,
  input  logic [NREQ*LW-1:0] req_len,
  output logic [NREQ-1:0]    ack,
  output logic [CW-1:0]      result,
  output logic               wrapped,
  output logic               busy,
  output logic [IW-1:0]      grant_id,
  output logic               ctr_ld,
  output logic               ctr_en,
  output logic [CW-1:0]      ctr_ld_val,
  input  logic [CW-1:0]      ctr_count
);

  cseq_state_e      state_q;
  logic [IW-1:0]    id_q;
  logic [LW-1:0]    rem_q;
  logic [NREQ-1:0]  ack_q;
  logic             ctr_ld_q;
  logic             ctr_en_q;
  logic [CW-1:0]    ld_val_q;

  logic             gnt_valid;
  logic [IW-1:0]    gnt_id;
  logic             grant_en;
  logic [CW-1:0]    sel_start;
  logic [LW-1:0]    sel_len;
  logic [NREQ-1:0]  id_onehot;
  logic             wrap_hit;

  assign grant_en  = (state_q == ST_IDLE) && gnt_valid;
  assign id_onehot = NREQ'(1) << id_q;

  cseq_rr_arb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .grant_en  (grant_en),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Job fields of the winning requester, captured only at grant.
  always_comb begin
    sel_start = '0;
    sel_len   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_id == IW'(i)) begin
        sel_start = req_start[i*CW +: CW];
        sel_len   = req_len[i*LW +: LW];
      end
    end
  end

`ifdef CSEQ_WRAP_STOP_EN
  logic wrapped_q;
  // Increment out of all-ones wraps the counter to zero: stop the job there.
  assign wrap_hit = (state_q == ST_RUN) && (ctr_count == {CW{1'b1}});
  assign wrapped  = wrapped_q;
`else
  assign wrap_hit = 1'b0;
  assign wrapped  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      rem_q     <= '0;
      ack_q     <= '0;
      ctr_ld_q  <= 1'b0;
      ctr_en_q  <= 1'b0;
      ld_val_q  <= '0;
`ifdef CSEQ_WRAP_STOP_EN
      wrapped_q <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            state_q  <= ST_LOAD;
            id_q     <= gnt_id;
            ld_val_q <= sel_start;
            rem_q    <= sel_len;
            ctr_ld_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          ctr_ld_q <= 1'b0;
          if (rem_q != '0) begin
            state_q  <= ST_RUN;
            ctr_en_q <= 1'b1;
          end else begin
            state_q <= ST_DONE;
            ack_q   <= id_onehot;
          end
        end
        ST_RUN: begin
          rem_q <= rem_q - LW'(1);
          if ((rem_q == LW'(1)) || wrap_hit) begin
            state_q   <= ST_DONE;
            ctr_en_q  <= 1'b0;
            ack_q     <= id_onehot;
`ifdef CSEQ_WRAP_STOP_EN
            wrapped_q <= wrap_hit;
`endif
          end
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
`ifdef CSEQ_WRAP_STOP_EN
          wrapped_q <= 1'b0;
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // The final increment lands on the edge entering DONE, so the live count
  // during DONE is the job result.
  assign result     = (state_q == ST_DONE) ? ctr_count : '0;
  assign ack        = ack_q;
  assign busy       = (state_q != ST_IDLE);
  assign grant_id   = id_q;
  assign ctr_ld     = ctr_ld_q;
  assign ctr_en     = ctr_en_q;
  assign ctr_ld_val = ld_val_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb/tb_count_seq_ctrl.sv - scoreboard bench for count_seq_ctrl with a behavioural counter
module tb_count_seq_ctrl;

  localparam int NREQ = 2;
  localparam int CW   = 3;
  localparam int LW   = 4;
  localparam int IW   = 1;

`ifdef CSEQ_WRAP_STOP_EN
  localparam int WS = 1;
`else
  localparam int WS = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*CW-1:0] req_start = '0;
  logic [NREQ*LW-1:0] req_len = '0;
  logic [NREQ-1:0]    ack;
  logic [CW-1:0]      result;
  logic               wrapped;
  logic               busy;
  logic [IW-1:0]      grant_id;
  logic               ctr_ld;
  logic               ctr_en;
  logic [CW-1:0]      ctr_ld_val;
  logic [CW-1:0]      ctr_count;

  count_seq_ctrl #(.NREQ(NREQ), .CW(CW), .LW(LW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_start(req_start), .req_len(req_len),
    .ack(ack), .result(result), .wrapped(wrapped), .busy(busy),
    .grant_id(grant_id), .ctr_ld(ctr_ld), .ctr_en(ctr_en),
    .ctr_ld_val(ctr_ld_val), .ctr_count(ctr_count)
  );

  always #5 clk = ~clk;

  // Shared counter instance model
  always @(posedge clk) begin
    if (rst)         ctr_count <= '0;
    else if (ctr_ld) ctr_count <= ctr_ld_val;
    else if (ctr_en) ctr_count <= ctr_count + 3'd1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ack;
    int res;
    int wr;
    int cyc;
    int id;
    int ldv;
    int en;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: tracks load/enable activity per job and scores each ack.
  int en_cnt = 0;
  int ldv_seen = 0;
  int overlap = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      en_cnt  = 0;
      overlap = 0;
    end else begin
      if (ctr_ld && ctr_en) overlap = 1;
      if (ctr_ld) begin
        en_cnt   = 0;
        ldv_seen = int'(ctr_ld_val);
      end
      if (ctr_en) en_cnt++;
      if (ack != '0) begin
        if (q.size() == 0) begin
          check("unexpected_ack", int'(ack), 0);
        end else begin
          e = q.pop_front();
          check("ack_onehot", int'(ack), e.ack);
          check("ack_cycle", cyc, e.cyc);
          check("result", int'(result), e.res);
          check("wrapped", int'(wrapped), e.wr);
          check("grant_id", int'(grant_id), e.id);
          check("ld_val", ldv_seen, e.ldv);
          check("en_cycles", en_cnt, e.en);
          check("busy_at_ack", int'(busy), 1);
          check("ld_en_overlap", overlap, 0);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, int'(ack), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_wrapped"}, int'(wrapped), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_grant_id"}, int'(grant_id), 0);
    check({tag, "_ctr_ld"}, int'(ctr_ld), 0);
    check({tag, "_ctr_en"}, int'(ctr_en), 0);
    check({tag, "_ctr_ld_val"}, int'(ctr_ld_val), 0);
  endtask

  task automatic set_job(input int id, input int st, input int ln);
    req_start[id*CW +: CW] = CW'(st);
    req_len[id*LW +: LW]   = LW'(ln);
  endtask

  task automatic push(input int id, input int res, input int wr, input int acyc,
                      input int ldv, input int en);
    exp_t e;
    e.ack = 1 << id; e.res = res; e.wr = wr; e.cyc = acyc;
    e.id = id; e.ldv = ldv; e.en = en;
    q.push_back(e);
  endtask

  // Issue one job at a negedge; eff is the number of increments expected.
  task automatic single_job(input int id, input int st, input int ln,
                            input int res, input int wr, input int eff);
    int t;
    set_job(id, st, ln);
    req[id] = 1'b1;
    t = cyc;
    push(id, res, wr, t + 2 + eff, st, eff);
    repeat (eff + 2) @(negedge clk);
    req[id] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(negedge clk);

    // start=2 len=3 -> result 5 at T+5
    single_job(0, 2, 3, 5, 0, 3);
    // len=0 start=4 -> ack at T+2, no enables
    single_job(1, 4, 0, 4, 0, 0);
    // start=6 len=5: natural wrap to 3, or early stop at zero
    if (WS != 0) single_job(0, 6, 5, 0, 1, 2);
    else         single_job(0, 6, 5, 3, 0, 5);

    // start changed after grant: result uses latched start 1 -> 3
    set_job(1, 1, 2);
    req[1] = 1'b1;
    t = cyc;
    push(1, 3, 0, t + 4, 1, 2);
    @(negedge clk);
    req_start[1*CW +: CW] = 3'd5;
    repeat (3) @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);

    // Fresh reset, both held: grants alternate 0,1,0,1
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_job(0, 1, 1);
    set_job(1, 3, 2);
    req = 2'b11;
    t = cyc;
    push(0, 2, 0, t + 3, 1, 1);
    push(1, 5, 0, t + 8, 3, 2);
    push(0, 2, 0, t + 12, 1, 1);
    push(1, 5, 0, t + 17, 3, 2);
    repeat (17) @(negedge clk);
    req = 2'b00;
    @(negedge clk);

    // Reset in RUN abandons requester 0's job with no ack
    set_job(0, 0, 6);
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_run");
    req = 2'b00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    // After reset requester 0 wins even though it was granted last
    set_job(0, 7, 1);
    set_job(1, 3, 1);
    req = 2'b11;
    t = cyc;
    push(0, 0, WS, t + 3, 7, 1);
    push(1, 4, 0, t + 7, 3, 1);
    repeat (3) @(negedge clk);
    req[0] = 1'b0;
    repeat (4) @(negedge clk);
    req[1] = 1'b0;

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
